// File: rtl/asic_iocorner_pkg.sv
// asic_iocorner_pkg: shared FSM state type, stage limit and delay helper for the IO corner sequencer
package asic_iocorner_pkg;

    localparam int MAX_STAGES = 4;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} seq_state_t;

    function automatic int unsigned max1(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/asic_iocorner_sync.sv
// asic_iocorner_sync: 2-flop async-reset synchronizer bringing pwr_ok into the ring clock domain
module asic_iocorner_sync (
    input  logic clk,
    input  logic nreset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    // shift the async level through two flops, cleared on reset
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) r_sync <= '0;
        else         r_sync <= {r_sync[0], i_d};

    assign o_q = r_sync[1];

endmodule

// File: rtl/asic_iocorner_seq.sv
// asic_iocorner_seq: IO ring corner retiming the control ring and sequencing lane release after power-good
// Optional parity checking is built when ASIC_IOCORNER_PARITY_EN is defined.
module asic_iocorner_seq
    import asic_iocorner_pkg::*;
#(
    parameter string TYPE   = "SOFT",
    parameter string DIR    = "NE",
    parameter int    NCTRL  = 8,
    parameter int    NSEQ   = 4,
    parameter int    STAGES = 1,
    parameter int    DLYW   = 8
) (
    input  logic                         clk,
    input  logic                         nreset,
    inout  wire                          vddio,
    inout  wire                          vssio,
    inout  wire                          vdd,
    inout  wire                          vss,
    input  logic                         pwr_ok,
    input  logic [DLYW-1:0]              dly,
    input  logic [NCTRL-1:0]             ctrl_in,
`ifdef ASIC_IOCORNER_PARITY_EN
    input  logic                         par_in,
    output logic                         par_err,
`endif
    output logic [NCTRL-1:0]             ctrl_out,
    output logic                         seq_done,
    output logic [$clog2(NSEQ+1)-1:0]    seq_lane
);

    localparam int LW  = $clog2(NSEQ + 1);
    localparam int NST = (STAGES > MAX_STAGES) ? MAX_STAGES : STAGES;

`ifdef ASIC_IOCORNER_PARITY_EN
    localparam int PW = NCTRL + 1;
`else
    localparam int PW = NCTRL;
`endif

    logic              w_pwr_s;
    logic [PW-1:0]     w_pipe_in;
    logic [PW-1:0]     w_pipe;
    logic [NCTRL-1:0]  w_gate;
    logic [DLYW-1:0]   w_load;
    logic              w_unused_rails;

    seq_state_t        r_state, w_state;
    logic [DLYW-1:0]   r_cnt, w_cnt;
    logic [NSEQ-1:0]   r_en_mask, w_en_mask;
    logic [LW-1:0]     r_lane, w_lane;
    logic              r_done, w_done;

    // rails and orientation are carried through the corner without affecting logic
    assign w_unused_rails = &{vddio, vssio, vdd, vss, TYPE == "SOFT", DIR == "NE"};

    asic_iocorner_sync u_sync (
        .clk    (clk),
        .nreset (nreset),
        .i_d    (pwr_ok),
        .o_q    (w_pwr_s)
    );

`ifdef ASIC_IOCORNER_PARITY_EN
    assign w_pipe_in = {par_in, ctrl_in};
`else
    assign w_pipe_in = ctrl_in;
`endif

    generate
        if (NST == 0) begin : g_comb
            assign w_pipe = nreset ? w_pipe_in : '0;
        end else begin : g_reg
            logic [PW-1:0] r_pipe [NST];
            // shift ring lanes through the retime stages
            always_ff @(posedge clk or negedge nreset)
                if (!nreset) begin
                    for (int i = 0; i < NST; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_pipe_in;
                    for (int i = 1; i < NST; i++) r_pipe[i] <= r_pipe[i-1];
                end
            assign w_pipe = r_pipe[NST-1];
        end
    endgenerate

    // sequenced lanes are gated by the release mask, the rest pass straight through
    always_comb begin
        w_gate = '1;
        w_gate[NSEQ-1:0] = r_en_mask;
    end

    assign ctrl_out = w_pipe[NCTRL-1:0] & w_gate;
    assign w_load   = DLYW'(max1(32'(dly)) - 1);

    // sequencer state, delay counter and release bookkeeping
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_en_mask <= '0;
            r_lane    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_en_mask <= w_en_mask;
            r_lane    <= w_lane;
            r_done    <= w_done;
        end

    // next-state: brown-out wins over everything, otherwise count down and release lanes in order
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_en_mask = r_en_mask;
        w_lane    = r_lane;
        w_done    = r_done;
        if (!w_pwr_s) begin
            w_state   = IDLE;
            w_en_mask = '0;
            w_lane    = '0;
            w_done    = 1'b0;
        end else if (r_state == IDLE) begin
            w_cnt   = w_load;
            w_state = WAIT;
        end else if (r_state == WAIT) begin
            if (r_cnt != '0) begin
                w_cnt = r_cnt - 1'b1;
            end else begin
                w_en_mask = r_en_mask | (NSEQ'(1) << r_lane);
                w_lane    = r_lane + 1'b1;
                if (r_lane == LW'(NSEQ - 1)) begin
                    w_state = DONE;
                    w_done  = 1'b1;
                end else begin
                    w_cnt = w_load;
                end
            end
        end
    end

    assign seq_done = r_done;
    assign seq_lane = r_lane;

`ifdef ASIC_IOCORNER_PARITY_EN
    logic r_par_err;

    // sticky flag once released lanes disagree with their retimed parity bit
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) r_par_err <= 1'b0;
        else if (r_state == DONE && ((^w_pipe[NCTRL-1:0]) != w_pipe[NCTRL])) r_par_err <= 1'b1;

    assign par_err = r_par_err;
`endif

endmodule

// File: tb/tb_asic_iocorner_seq.sv
// tb_asic_iocorner_seq: scoreboard bench for the IO corner retime and power-up sequencer
module tb_asic_iocorner_seq;

    logic       clk = 1'b0;
    logic       nreset;
    logic       pwr_ok;
    logic [7:0] dly;
    logic [7:0] ctrl_in;
    logic [7:0] ctrl_out;
    logic       seq_done;
    logic [2:0] seq_lane;
    wire        vddio, vssio, vdd, vss;
`ifdef ASIC_IOCORNER_PARITY_EN
    logic       par_in;
    logic       par_err;
`endif

    assign vddio = 1'b1;
    assign vssio = 1'b0;
    assign vdd   = 1'b1;
    assign vss   = 1'b0;

    asic_iocorner_seq dut (
        .clk      (clk),
        .nreset   (nreset),
        .vddio    (vddio),
        .vssio    (vssio),
        .vdd      (vdd),
        .vss      (vss),
        .pwr_ok   (pwr_ok),
        .dly      (dly),
        .ctrl_in  (ctrl_in),
`ifdef ASIC_IOCORNER_PARITY_EN
        .par_in   (par_in),
        .par_err  (par_err),
`endif
        .ctrl_out (ctrl_out),
        .seq_done (seq_done),
        .seq_lane (seq_lane)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] out;
        logic [2:0] lane;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // expectation with ctrl_in held at 8'hFF and n lanes released
    task automatic ex(input int at, input int n);
        exp_t e;
        e.at   = at;
        e.out  = 8'hF0 | 8'((1 << n) - 1);
        e.lane = 3'(n);
        e.done = (n == 4);
        sb.push_back(e);
    endtask

    task automatic ex_raw(input int at, input logic [7:0] out, input int n, input logic done);
        exp_t e;
        e.at   = at;
        e.out  = out;
        e.lane = 3'(n);
        e.done = done;
        sb.push_back(e);
    endtask

    function automatic int dmax(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    // pwr_ok high at negedge c: two sync flops, one load edge, then a release every dmax(d) edges
    task automatic push_seq(input int c, input int d);
        ex(c + 2 + dmax(d), 0);
        for (int n = 1; n <= 4; n++) ex(c + 3 + dmax(d) * n, n);
    endtask

    task automatic run_seq(input int d);
        int c;
        dly    = 8'(d);
        c      = cyc;
        pwr_ok = 1'b1;
        push_seq(c, d);
        repeat (4 + 4 * dmax(d)) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);
    endtask

    // brown-out from DONE: old lanes hold until pwr_s falls, then clear one edge later
    task automatic bo_done();
        int d;
        d      = cyc;
        pwr_ok = 1'b0;
        ex(d + 2, 4);
        ex(d + 3, 0);
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.at < cyc) check("sb_late", 32'(cyc), 32'(e.at));
            else begin
                check("ctrl_out", 32'(ctrl_out), 32'(e.out));
                check("seq_lane", 32'(seq_lane), 32'(e.lane));
                check("seq_done", 32'(seq_done), 32'(e.done));
            end
        end
    end

    initial begin
        int c, r, x;
        nreset  = 1'b0;
        pwr_ok  = 1'b0;
        dly     = 8'd3;
        ctrl_in = 8'hFF;
`ifdef ASIC_IOCORNER_PARITY_EN
        par_in  = 1'b0;
`endif
        #1;
        check("rst_out",  32'(ctrl_out), 0);
        check("rst_lane", 32'(seq_lane), 0);
        check("rst_done", 32'(seq_done), 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        r = cyc;
        ex(r + 1, 0);
        ex(r + 4, 0);
        repeat (5) @(negedge clk);

        run_seq(3);

        x = cyc;
        ctrl_in = 8'h5A;
        ex_raw(x + 1, 8'h5A, 4, 1'b1);
        @(negedge clk);
        ctrl_in = 8'h3C;
        ex_raw(x + 2, 8'h3C, 4, 1'b1);
        @(negedge clk);
        ctrl_in = 8'hFF;
        ex(x + 3, 4);
        repeat (2) @(negedge clk);

        bo_done();
        run_seq(0);
        bo_done();

        dly    = 8'd3;
        c      = cyc;
        pwr_ok = 1'b1;
        ex(c + 5, 0);
        ex(c + 6, 1);
        ex(c + 9, 2);
        repeat (9) @(negedge clk);
        pwr_ok = 1'b0;
        ex(c + 11, 2);
        ex(c + 12, 0);
        repeat (5) @(negedge clk);
        run_seq(3);
        bo_done();

        c      = cyc;
        pwr_ok = 1'b1;
        ex(c + 5, 0);
        ex(c + 6, 1);
        repeat (7) @(negedge clk);
        nreset = 1'b0;
        #1;
        check("nrst_out",  32'(ctrl_out), 0);
        check("nrst_lane", 32'(seq_lane), 0);
        check("nrst_done", 32'(seq_done), 0);
        @(negedge clk);
        nreset = 1'b1;
        r = cyc;
        push_seq(r, 3);
        repeat (16) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);

        bo_done();
        run_seq(255);

`ifdef ASIC_IOCORNER_PARITY_EN
        check("par_clean", 32'(par_err), 0);
        ctrl_in = 8'h01;
        @(negedge clk);
        check("par_early", 32'(par_err), 0);
        @(negedge clk);
        check("par_set", 32'(par_err), 1);
        ctrl_in = 8'hFF;
        repeat (3) @(negedge clk);
        check("par_sticky", 32'(par_err), 1);
        nreset = 1'b0;
        #1;
        check("par_clr", 32'(par_err), 0);
        @(negedge clk);
        nreset = 1'b1;
`endif

        repeat (2) @(negedge clk);
        check("sb_final", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
